// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both master request/response ports and the shared slave port.
// No logic here; it only groups wires and sets their direction.
// Flow control is req/gnt on the master side; the slave side is strobed and has no backpressure.
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wd;
    logic                  m0_gnt;
    logic                  m0_valid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wd;
    logic                  m1_gnt;
    logic                  m1_valid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  s_we;
    logic                  s_re;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wd;
    logic [DATA_WIDTH-1:0] s_rd;

    // Environment side: the two requesting masters plus the memory-map slave
    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        output m1_req, m1_we, m1_addr, m1_wd,
        output s_rd,
        input  m0_gnt, m0_valid, m0_rdata,
        input  m1_gnt, m1_valid, m1_rdata,
        input  s_we, s_re, s_addr, s_wd
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        input  s_rd,
        output m0_gnt, m0_valid, m0_rdata,
        output m1_gnt, m1_valid, m1_rdata,
        output s_we, s_re, s_addr, s_wd
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter onto one memory-map slave; m0 has priority and m1 gets a guaranteed slot after MAX_BURST m0 wins.
// Latency: grant in cycle N, slave access in N+1, response valid in N+2; one transaction per cycle sustained.
// Backpressure: a master holds req until gnt; losing master simply waits, slave side never stalls.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    logic [3:0]            starve_cnt;
    logic                  acc_owner;
    logic                  m1_wins;
    logic                  gnt0;
    logic                  gnt1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wd;

    // Winner selection: m1 wins when alone or once m0 has used up its burst allowance
    always_comb begin
        m1_wins  = bus.m1_req && (!bus.m0_req || (starve_cnt == BURST_LIMIT));
        gnt1     = !rst && m1_wins;
        gnt0     = !rst && bus.m0_req && !m1_wins;
        sel_we   = m1_wins ? bus.m1_we   : bus.m0_we;
        sel_addr = m1_wins ? bus.m1_addr : bus.m0_addr;
        sel_wd   = m1_wins ? bus.m1_wd   : bus.m0_wd;
    end

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    // Slave-side register stage, starvation counter and response return in one FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.s_we     <= 1'b0;
            bus.s_re     <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wd     <= '0;
            bus.m0_valid <= 1'b0;
            bus.m1_valid <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
            starve_cnt   <= 4'd0;
            acc_owner    <= 1'b0;
        end else begin
            // Response: the access running this cycle is returned to its owner next cycle
            bus.m0_valid <= 1'b0;
            bus.m1_valid <= 1'b0;
            if (state == ACCESS) begin
                if (acc_owner) begin
                    bus.m1_valid <= 1'b1;
                    if (bus.s_re) begin
                        bus.m1_rdata <= bus.s_rd;
                    end
                end else begin
                    bus.m0_valid <= 1'b1;
                    if (bus.s_re) begin
                        bus.m0_rdata <= bus.s_rd;
                    end
                end
            end

            // Request stage: launch the winner onto the slave port
            if (gnt0 || gnt1) begin
                state      <= ACCESS;
                bus.s_we   <= sel_we;
                bus.s_re   <= !sel_we;
                bus.s_addr <= sel_addr;
                bus.s_wd   <= sel_wd;
                acc_owner  <= gnt1;
                if (gnt1 || !bus.m1_req) begin
                    starve_cnt <= 4'd0;
                end else if (starve_cnt != BURST_LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                state    <= IDLE;
                bus.s_we <= 1'b0;
                bus.s_re <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter with a queue-based scoreboard.
// Expected slave accesses and responses are queued at grant time and checked by an independent monitor.
// Slave memory is modelled as a pure function of the address.
module tb_mem_bus_arbiter;
    localparam int MAXB = 4;

    typedef struct {
        int          due;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        if (a == 32'h1001_0004) return 32'hDEAD_BEEF;
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    assign bus.s_rd = mem_of(bus.s_addr);

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int strobe_cnt = 0;

    item_t sq[$];
    item_t rq0[$];
    item_t rq1[$];

    // Master-side request state and reference model of the arbitration rules
    bit          act[2];
    logic        we_r[2];
    logic [31:0] addr_r[2];
    logic [31:0] wd_r[2];
    logic [31:0] last_rd[2];
    int          m0_run = 0;
    int          last_win = -1;
    bit          record = 0;
    int          wins[$];

    function automatic void chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    endfunction

    // Monitor: every cycle, any strobe or valid must match the head of its queue
    always @(posedge clk) begin
        item_t it;
        #1;
        cyc++;
        if (bus.s_we || bus.s_re) strobe_cnt++;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            it = sq.pop_front();
            chk("s_strobe", {62'd0, bus.s_we, bus.s_re}, {62'd0, it.we, !it.we});
            chk("s_addr", 64'(bus.s_addr), 64'(it.addr));
            if (it.we) chk("s_wd", 64'(bus.s_wd), 64'(it.wd));
        end else begin
            chk("s_quiet", {62'd0, bus.s_we, bus.s_re}, 64'd0);
        end
        if (rq0.size() > 0 && rq0[0].due == cyc) begin
            it = rq0.pop_front();
            chk("m0_valid", 64'(bus.m0_valid), 64'd1);
            chk("m0_rdata", 64'(bus.m0_rdata), 64'(it.rdata));
        end else begin
            chk("m0_valid_idle", 64'(bus.m0_valid), 64'd0);
        end
        if (rq1.size() > 0 && rq1[0].due == cyc) begin
            it = rq1.pop_front();
            chk("m1_valid", 64'(bus.m1_valid), 64'd1);
            chk("m1_rdata", 64'(bus.m1_rdata), 64'(it.rdata));
        end else begin
            chk("m1_valid_idle", 64'(bus.m1_valid), 64'd0);
        end
    end

    task automatic post(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        act[m]  = 1'b1;
        we_r[m] = we;
        addr_r[m] = addr;
        wd_r[m] = wd;
    endtask

    // One cycle of stimulus: issue new requests, then predict and check the grant
    task automatic step(input int p0, input int p1, input bit release_rst);
        int    p[2];
        int    win;
        item_t it;
        p[0] = p0;
        p[1] = p1;
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (!act[m] && $urandom_range(99) < p[m])
                post(m, 1'($urandom_range(1)), $urandom, $urandom);
        end
        bus.m0_req = act[0]; bus.m0_we = we_r[0]; bus.m0_addr = addr_r[0]; bus.m0_wd = wd_r[0];
        bus.m1_req = act[1]; bus.m1_we = we_r[1]; bus.m1_addr = addr_r[1]; bus.m1_wd = wd_r[1];
        #2;
        if (rst) win = -1;
        else if (act[1] && (!act[0] || m0_run >= MAXB)) win = 1;
        else if (act[0]) win = 0;
        else win = -1;
        chk("m0_gnt", 64'(bus.m0_gnt), 64'(win == 0));
        chk("m1_gnt", 64'(bus.m1_gnt), 64'(win == 1));
        last_win = win;
        if (win >= 0) begin
            if (win == 0) m0_run = act[1] ? ((m0_run < MAXB) ? m0_run + 1 : MAXB) : 0;
            else m0_run = 0;
            if (!we_r[win]) last_rd[win] = mem_of(addr_r[win]);
            it.we = we_r[win];
            it.addr = addr_r[win];
            it.wd = wd_r[win];
            it.rdata = last_rd[win];
            it.due = cyc + 1;
            sq.push_back(it);
            it.due = cyc + 2;
            if (win == 0) rq0.push_back(it);
            else rq1.push_back(it);
            act[win] = 1'b0;
            if (record) wins.push_back(win);
        end
    endtask

    initial begin
        int pat[10];
        int s0;
        logic [31:0] keep;
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        act = '{0, 0};
        we_r = '{0, 0};
        addr_r = '{0, 0};
        wd_r = '{0, 0};
        last_rd = '{0, 0};
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wd = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wd = 0;

        // Reset state
        #3;
        chk("rst_strobes", {62'd0, bus.s_we, bus.s_re}, 64'd0);
        chk("rst_s_addr", 64'(bus.s_addr), 64'd0);
        chk("rst_s_wd", 64'(bus.s_wd), 64'd0);
        chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'd0);
        chk("rst_valid", {62'd0, bus.m0_valid, bus.m1_valid}, 64'd0);
        step(0, 0, 0);
        step(0, 0, 1);

        // Single read with known data
        post(0, 1'b0, 32'h1001_0004, 32'h0);
        step(0, 0, 0);
        chk("single_gnt", 64'(last_win), 64'd0);
        repeat (3) step(0, 0, 0);
        chk("single_rdata", 64'(bus.m0_rdata), 64'hDEAD_BEEF);

        // m1 write acknowledgement keeps rdata
        keep = bus.m1_rdata;
        s0 = strobe_cnt;
        post(1, 1'b1, 32'h1001_0024, 32'h55);
        repeat (4) step(0, 0, 0);
        chk("wack_one_strobe", 64'(strobe_cnt - s0), 64'd1);
        chk("wack_rdata_kept", 64'(bus.m1_rdata), 64'(keep));

        // Starvation pattern with both requesting continuously
        record = 1;
        repeat (12) step(100, 100, 0);
        record = 0;
        act = '{0, 0};
        repeat (3) step(0, 0, 0);
        for (int i = 0; i < 10; i++) chk("starve_seq", 64'(wins[i]), 64'(pat[i]));

        // Three back-to-back m0 reads
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            post(0, 1'b0, 32'h1001_0100 + 32'(i * 4), 32'h0);
            step(0, 0, 0);
        end
        repeat (3) step(0, 0, 0);
        chk("b2b_strobes", 64'(strobe_cnt - s0), 64'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) step((i % 100 < 50) ? 50 : 90, (i % 70 < 35) ? 30 : 80, 0);
        act = '{0, 0};
        repeat (3) step(0, 0, 0);

        // Reset during the access cycle of an m1 read
        post(1, 1'b0, 32'h1001_0040, 32'h0);
        step(0, 0, 0);
        chk("rst_mid_gnt", 64'(last_win), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        sq.delete(); rq0.delete(); rq1.delete();
        m0_run = 0;
        last_rd = '{0, 0};
        #1;
        chk("rst_mid_s_re", 64'(bus.s_re), 64'd0);
        chk("rst_mid_gnt_forced", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
        post(0, 1'b0, 32'h1001_0080, 32'h0);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("post_rst_first_gnt", 64'(last_win), 64'd0);
        repeat (3) step(0, 0, 0);

        // Idle: no requests for 10 cycles
        s0 = strobe_cnt;
        repeat (10) step(0, 0, 0);
        chk("idle_strobes", 64'(strobe_cnt - s0), 64'd0);

        chk("drained", 64'(sq.size() + rq0.size() + rq1.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single memory-map slave port (RAM/UART address decode) between the core data port (master 0) and a secondary bus master (master 1, e.g. UART boot loader or debug port). Master 0 has fixed priority, bounded by a starvation limit that guarantees master 1 a slot. The block registers the winning request onto the slave side and returns the read data or write acknowledgement to the owning master with fixed latency. It sits between the cores and `master_memory_map`.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- MAX_BURST, 4, consecutive master-0 grants allowed while master 1 waits (range 1–15)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- m0_req  input  1  master 0 request; held with fields stable until granted
- m0_we  input  1  master 0: 1 = write, 0 = read
- m0_addr  input  ADDR_WIDTH  master 0 address
- m0_wd  input  DATA_WIDTH  master 0 write data
- m0_gnt  output  1  master 0 request accepted this cycle (combinational)
- m0_valid  output  1  one-cycle response pulse to master 0
- m0_rdata  output  DATA_WIDTH  master 0 read data, valid with m0_valid
- m1_req, m1_we, m1_addr, m1_wd, m1_gnt, m1_valid, m1_rdata: same as master 0, for master 1
- s_we  output  1  slave write strobe (registered)
- s_re  output  1  slave read strobe (registered)
- s_addr  output  ADDR_WIDTH  slave address (registered)
- s_wd  output  DATA_WIDTH  slave write data (registered)
- s_rd  input  DATA_WIDTH  slave read data, combinational from s_addr within the access cycle

## Operation
- States: IDLE (no slave access this cycle) and ACCESS (s_we or s_re is asserted this cycle).
- Arbitration runs every cycle in both states, so one transaction per cycle is sustained.
  - Winner is m0 if m0_req, except when m1_req=1 and starve_cnt==MAX_BURST; then m1 wins.
  - If only m1_req is high, m1 wins.
  - Exactly one gnt is high at a time. gnt is forced to 0 while rst is high.
- On a grant:
  - Latch addr/wd into s_addr/s_wd.
  - Set s_we=we and s_re=~we.
  - Latch the owner ID into acc_owner.
  - Next state is ACCESS.
- With no grant: s_we=s_re=0, s_addr/s_wd hold, next state is IDLE.
- Response path:
  - In ACCESS, s_rd is sampled into the owner's mX_rdata at the clock edge.
  - The owner's mX_valid pulses for the following cycle.
  - Writes also produce a valid pulse, with mX_rdata unchanged. It serves as the write acknowledgement.
  - A non-owner's valid stays 0.
- starve_cnt is 4 bits:
  - increments (saturating at MAX_BURST) on an m0 grant while m1_req=1;
  - clears on an m1 grant;
  - clears on an m0 grant while m1_req=0.
- Masters must not drop req before gnt. Behaviour is undefined if they do, but the block must not grant a request that is low in the same cycle.

## Timing
- Cycle N: req high and arbitration won → mX_gnt=1 combinationally.
- Cycle N+1: s_addr/s_wd/s_we|s_re driven (state ACCESS).
- Cycle N+2: mX_valid=1; mX_rdata = s_rd from cycle N+1.
- Latency from grant to response is fixed at 2 cycles. Back-to-back grants give back-to-back valids in grant order.
- Simultaneous m0_req and m1_req in IDLE: m0 wins unless the starvation condition holds.
- Reset values (asynchronous, any state, including mid-transaction):
  - state=IDLE;
  - s_we=s_re=0, s_addr=0, s_wd=0;
  - m0_valid=m1_valid=0, m0_rdata=m1_rdata=0;
  - starve_cnt=0, acc_owner=0.
- An access in flight at reset is dropped, with no valid after rst deasserts.
- First grant possible in the first clock cycle after rst deasserts.

## Test plan
- Single read: m0 read addr 0x10010004, s_rd=0xDEADBEEF during access → m0_gnt at N, s_re=1 and s_addr=0x10010004 at N+1, m0_valid=1 with m0_rdata=0xDEADBEEF at N+2, m1_valid=0 throughout.
- Write ack: m1 write addr 0x10010024, wd 0x55 → s_we=1, s_wd=0x55 for exactly one cycle, then m1_valid pulse with m1_rdata unchanged.
- Starvation: m0_req and m1_req held high continuously, MAX_BURST=4 → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1…; valids follow the same order, 2 cycles after each grant.
- Back-to-back: m0 issues 3 consecutive reads with m1 idle → state ACCESS for 3 consecutive cycles, 3 consecutive m0_valid pulses with data in order, then IDLE.
- Reset mid-operation: assert rst in the ACCESS cycle of an m1 read → s_re drops immediately; no m1_valid after release; next m0 request is granted in the first cycle after rst falls.
- Idle check: both req low for 10 cycles → no gnt, s_we=s_re=0, valids 0, state IDLE.
